hazard_scoreboard: RTL and testbench

Issue-side hazard tracker for the 8-register pipelined core; it is the producer-side counterpart of the writeback forwarding logic. It records every in-flight register write at issue and retires it when the same write appears on the writeback port (`writereg`/`regwrite`). It gates issue with a stall when a source register depends on a load result that is not yet forwardable, or when a per-register tracking counter would overflow. It also exports per-register busy state for debug and for the forwarding muxes.

---
 rtl/hazard_scoreboard.sv | 198 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Issue-side hazard tracker for the 8-register pipelined core. Each register
// has a small in-flight write counter: it goes up when a write is accepted at
// issue and down when that write shows up on the writeback port. A second
// per-register countdown (ldc) covers load results that cannot be forwarded
// yet. Issue is stalled on a load-use dependency or when the destination
// counter is already at its maximum.
//
// Parameters
//   CNTW      width of each in-flight counter (max count 2^CNTW-1)
//   LOAD_LAT  cycles after load acceptance before the result is forwardable
//             (1..7)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-low reset
//   issue_valid     decode presents an instruction
//   issue_rd        destination register of that instruction
//   issue_regwrite  instruction writes issue_rd
//   issue_osrc      result source: 1 = load, 0 = ALU
//   rs1, rs2        source registers
//   rs1_used/rs2_used  corresponding source is actually read
//   writereg        writeback destination register
//   regwrite        writeback commits a write this cycle
//   stall           combinational: instruction must not advance
//   issue_ack       combinational: issue accepted this cycle
//   busy            per-register "counter nonzero"
//   inflight        registered total of in-flight writes (4-bit, wraps)
//   err             sticky: writeback seen for a register with no write
//                   in flight
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int CNTW     = 2,
  parameter int LOAD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [2:0] issue_rd,
  input  logic       issue_regwrite,
  input  logic       issue_osrc,
  input  logic [2:0] rs1,
  input  logic [2:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [2:0] writereg,
  input  logic       regwrite,
  output logic       stall,
  output logic       issue_ack,
  output logic [7:0] busy,
  output logic [3:0] inflight,
  output logic       err
);

  localparam int NREG = 8;

  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] CNT_ZERO = '0;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [2:0]      LD_INIT  = 3'(LOAD_LAT);

  // Elaboration-time guard: the load countdown is 3 bits wide.
  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
    $error("hazard_scoreboard: LOAD_LAT must be in 1..7");
  end
  if (CNTW < 1) begin : g_bad_cntw
    $error("hazard_scoreboard: CNTW must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [2:0]      ldc_q [NREG];
  logic [2:0]      ldc_d [NREG];
  logic [3:0]      inflight_d;
  logic            err_d;

  // ---------------------------------------------------------------------------
  // Hazard detection and issue handshake
  // ---------------------------------------------------------------------------
  logic hz_ld;
  logic hz_sat;
  logic wr_acc;   // accepted instruction that writes a register
  logic ret_ok;   // retire of a register with a write in flight
  logic ret_bad;  // retire of a register with nothing in flight

  always_comb begin
    // NOTE: every signal driven from always_comb gets a value on every path
    // (defaults first) so no latch is inferred.
    hz_ld     = 1'b0;
    hz_sat    = 1'b0;
    stall     = 1'b0;
    issue_ack = 1'b0;
    wr_acc    = 1'b0;
    ret_ok    = 1'b0;
    ret_bad   = 1'b0;

    // A load result is unforwardable while its countdown is nonzero. Only
    // sources that are really read can create a dependency.
    hz_ld  = (rs1_used && (ldc_q[rs1] != 3'd0)) ||
             (rs2_used && (ldc_q[rs2] != 3'd0));
    // Another write to a full counter would wrap it.
    hz_sat = issue_regwrite && (cnt_q[issue_rd] == CNT_MAX);

    // Stall depends only on current state and issue inputs, never on the
    // same-cycle retire, to keep the decode path short.
    stall     = issue_valid && (hz_ld || hz_sat);
    issue_ack = issue_valid && !stall;

    wr_acc  = issue_ack && issue_regwrite;
    ret_ok  = regwrite && (cnt_q[writereg] != CNT_ZERO);
    ret_bad = regwrite && (cnt_q[writereg] == CNT_ZERO);
  end

  // ---------------------------------------------------------------------------
  // Next-state computation per register
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      ldc_d[r] = ldc_q[r];
    end
    busy       = '0;
    inflight_d = inflight;
    err_d      = err;

    for (int r = 0; r < NREG; r++) begin
      logic inc;
      logic dec;
      inc = wr_acc && (issue_rd == 3'(r));
      dec = ret_ok && (writereg == 3'(r));

      // A write and a retire of the same register cancel out. A retire of
      // an idle register never decrements (ret_ok is false), so an accepted
      // write in that same cycle still counts.
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end

      // Load countdown: free-running decrement; a new load reloads it, and
      // retiring the last in-flight write means the value is already in the
      // register file, so the countdown is cleared early.
      if (ldc_q[r] != 3'd0) begin
        ldc_d[r] = ldc_q[r] - 3'd1;
      end
      if (inc && issue_osrc) begin
        ldc_d[r] = LD_INIT;
      end else if (dec && !inc && (cnt_q[r] == CNT_ONE)) begin
        ldc_d[r] = 3'd0;
      end

      busy[r] = (cnt_q[r] != CNT_ZERO);
    end

    // The running total tracks exactly the counter increments/decrements.
    unique case ({wr_acc, ret_ok})
      2'b10:   inflight_d = inflight + 4'd1;
      2'b01:   inflight_d = inflight - 4'd1;
      default: inflight_d = inflight;
    endcase

    if (ret_bad) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: cnt/ldc are small flop arrays, not a RAM macro, so they are
      // reset like any other control state; the hazard logic depends on it.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= CNT_ZERO;
        ldc_q[r] <= 3'd0;
      end
      inflight <= 4'd0;
      err      <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
        ldc_q[r] <= ldc_d[r];
      end
      inflight <= inflight_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_scoreboard.
//
// The driver applies one cycle of stimulus at each falling edge, computes the
// expected outputs from a behavioural model and pushes them into a queue. The
// monitor pops one entry per cycle, a little after the falling edge, and
// compares. The model tracks per-register in-flight counts and, for loads,
// the absolute cycle number from which the result is forwardable.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int CNTW     = 2;
  localparam int LOAD_LAT = 2;
  localparam int CMAX     = (1 << CNTW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_rd = 3'd0;
  logic       issue_regwrite = 1'b0;
  logic       issue_osrc = 1'b0;
  logic [2:0] rs1 = 3'd0;
  logic [2:0] rs2 = 3'd0;
  logic       rs1_used = 1'b0;
  logic       rs2_used = 1'b0;
  logic [2:0] writereg = 3'd0;
  logic       regwrite = 1'b0;
  logic       stall;
  logic       issue_ack;
  logic [7:0] busy;
  logic [3:0] inflight;
  logic       err;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNTW(CNTW), .LOAD_LAT(LOAD_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_regwrite(issue_regwrite),
    .issue_osrc    (issue_osrc),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_used      (rs1_used),
    .rs2_used      (rs2_used),
    .writereg      (writereg),
    .regwrite      (regwrite),
    .stall         (stall),
    .issue_ack     (issue_ack),
    .busy          (busy),
    .inflight      (inflight),
    .err           (err)
  );

  typedef struct {
    bit         chk;
    logic       stall;
    logic       ack;
    logic [7:0] busy;
    logic [3:0] inflight;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model
  int m_cnt[8];
  int m_ready[8];      // first cycle in which the register's load is forwardable
  bit m_err = 1'b0;
  bit m_known = 1'b0;  // state defined (after first reset edge)
  bit m_last_stall = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus model update.
  task automatic step(input bit r, input bit v, input logic [2:0] rd, input bit rw,
                      input bit os, input logic [2:0] a, input logic [2:0] b,
                      input bit au, input bit bu, input logic [2:0] wr,
                      input bit wv, input string tag);
    exp_t e;
    bit   hz_ld, hz_sat, acc;
    int   old_cnt[8];
    int   sum;
    @(negedge clk);
    rst = r; issue_valid = v; issue_rd = rd; issue_regwrite = rw; issue_osrc = os;
    rs1 = a; rs2 = b; rs1_used = au; rs2_used = bu; writereg = wr; regwrite = wv;

    hz_ld  = (au && cyc < m_ready[a]) || (bu && cyc < m_ready[b]);
    hz_sat = rw && (m_cnt[rd] == CMAX);
    e.chk   = m_known;
    e.stall = v && (hz_ld || hz_sat);
    e.ack   = v && !e.stall;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      e.busy[i] = (m_cnt[i] != 0);
      sum += m_cnt[i];
    end
    e.inflight = 4'(sum % 16);
    e.err = m_err;
    e.tag = tag;
    sbq.push_back(e);
    m_last_stall = e.stall;

    // State after the rising edge.
    if (!r) begin
      for (int i = 0; i < 8; i++) begin
        m_cnt[i] = 0;
        m_ready[i] = 0;
      end
      m_err = 1'b0;
      m_known = 1'b1;
      m_last_stall = 1'b0;
    end else begin
      old_cnt = m_cnt;
      acc = e.ack && rw;
      if (acc) begin
        m_cnt[rd]++;
        if (os) m_ready[rd] = cyc + LOAD_LAT + 1;
      end
      if (wv) begin
        if (old_cnt[wr] > 0) begin
          m_cnt[wr]--;
          if (m_cnt[wr] == 0) m_ready[wr] = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // Monitor: one expected entry per cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          check({e.tag, ".stall"},     32'(stall),     32'(e.stall));
          check({e.tag, ".issue_ack"}, 32'(issue_ack), 32'(e.ack));
          check({e.tag, ".busy"},      32'(busy),      32'(e.busy));
          check({e.tag, ".inflight"},  32'(inflight),  32'(e.inflight));
          check({e.tag, ".err"},       32'(err),       32'(e.err));
        end
      end
    end
  end

  initial begin
    logic [2:0] h_rd, h_a, h_b, h_wr;
    bit h_v, h_rw, h_os, h_au, h_bu, h_wv, h_r;
    int cands[$];

    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_ready[i] = 0;
    end

    // Reset with issue and retire presented: both must be ignored.
    step(0, 1, 3, 1, 1, 0, 0, 0, 0, 3, 1, "reset0");
    step(0, 1, 3, 1, 1, 0, 0, 0, 0, 3, 1, "reset1");
    step(1, 1, 0, 0, 0, 1, 2, 1, 1, 0, 0, "clean_issue");

    // ALU write to r3, consumer, retire.
    step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, "alu_w3");
    step(1, 1, 7, 0, 0, 3, 0, 1, 0, 0, 0, "alu_use3");
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, "alu_ret3");
    idle(1);

    // Load-use on r5: stall, stall, accept.
    step(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, "ld5");
    for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 5, 0, 1, 0, 0, "ld_use5");
    step(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, "ld5b");
    step(1, 1, 7, 0, 0, 0, 5, 0, 0, 0, 0, "ld_nouse5");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, "ret5a");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, "ret5b");

    // Saturation on r1.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "sat_w1");
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "sat_stall");
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, "sat_stall_ret");
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "sat_accept");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "sat_drain");

    // Simultaneous write and retire of r2, then error on idle r4.
    step(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, "sim_w2");
    step(1, 1, 2, 1, 0, 0, 0, 0, 0, 2, 1, "sim_w2_ret2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, "sim_ret2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, "err_ret4");
    idle(3);

    // Early retire of a load to r6.
    step(1, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0, "early_ld6");
    step(1, 1, 7, 0, 0, 6, 0, 1, 0, 6, 1, "early_ret6");
    step(1, 1, 7, 0, 0, 6, 0, 1, 0, 0, 0, "early_use6");
    idle(1);

    // Randomized traffic with occasional resets.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rnd_reset");
    {h_v, h_rd, h_rw, h_os, h_a, h_b, h_au, h_bu} = '0;
    for (int n = 0; n < 3000; n++) begin
      h_r = ($urandom_range(0, 299) != 0);
      if (!(m_last_stall && h_v)) begin
        h_v  = ($urandom_range(0, 3) != 0);
        h_rd = 3'($urandom_range(0, 7));
        h_rw = ($urandom_range(0, 9) < 7);
        h_os = ($urandom_range(0, 9) < 4);
        h_a  = 3'($urandom_range(0, 7));
        h_b  = 3'($urandom_range(0, 7));
        h_au = $urandom_range(0, 1) != 0;
        h_bu = $urandom_range(0, 1) != 0;
      end
      cands.delete();
      for (int i = 0; i < 8; i++) if (m_cnt[i] > 0) cands.push_back(i);
      h_wv = (cands.size() > 0) && ($urandom_range(0, 1) != 0);
      h_wr = h_wv ? 3'(cands[$urandom_range(0, cands.size() - 1)]) : 3'd0;
      step(h_r, h_v, h_rd, h_rw, h_os, h_a, h_b, h_au, h_bu, h_wr, h_wv, "rnd");
    end
    idle(2);

    // Let the monitor drain; an undrained queue counts as a failure.
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
